// File: rtl/loop_nest_monitor.sv
// loop_nest_monitor: receiving-end checker for a nested-loop action sequencer.
// Tracks the outer/inner index of the next expected action, detects frame
// completion after OUTER*INNER actions, counts cleanly closed frames and keeps
// sticky flags for extra actions (overrun) and premature clears (underrun).
module loop_nest_monitor #(
  parameter int OUTER = 10,
  parameter int INNER = 10,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act_stb,
  input  logic         clr,
  input  logic         err_clr,
  output logic [W-1:0] x_idx,
  output logic [W-1:0] y_idx,
  output logic [W-1:0] act_cnt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] frame_cnt,
  output logic         overrun,
  output logic         underrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [W-1:0] TOTAL_W = W'(OUTER * INNER);
  localparam logic [W-1:0] X_LAST  = W'(OUTER - 1);
  localparam logic [W-1:0] Y_LAST  = W'(INNER - 1);
  localparam logic [W-1:0] ONE_W   = W'(1);
  localparam logic [W-1:0] ZERO_W  = {W{1'b0}};

  state_t       state_r;
  logic [W-1:0] nxt_x_s;
  logic [W-1:0] nxt_y_s;
  logic [W-1:0] nxt_cnt_s;
  logic         cnt_full_s;
  logic         ovr_evt_s;
  logic         und_evt_s;

  // Index/count values that an accepted strobe would load (inner loop wraps into outer).
  always_comb begin
    nxt_x_s   = x_idx;
    nxt_y_s   = y_idx;
    nxt_cnt_s = act_cnt + ONE_W;
    if (y_idx == Y_LAST) begin
      nxt_y_s = ZERO_W;
      if (x_idx == X_LAST) begin
        nxt_x_s = ZERO_W;
      end else begin
        nxt_x_s = x_idx + ONE_W;
      end
    end else begin
      nxt_y_s = y_idx + ONE_W;
    end
    cnt_full_s = (nxt_cnt_s == TOTAL_W);
  end

  // Protocol error events; clr wins over a same-cycle strobe, so a FULL strobe with clr is no overrun.
  assign ovr_evt_s = (state_r == FULL) && act_stb && !clr;
  assign und_evt_s = (state_r == RUN) && clr;

  // Sticky error flags: a new error event dominates a same-cycle err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (ovr_evt_s) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (und_evt_s) begin
        underrun <= 1'b1;
      end else if (err_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // Frame FSM with registered indices, counters, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      x_idx     <= ZERO_W;
      y_idx     <= ZERO_W;
      act_cnt   <= ZERO_W;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= ZERO_W;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!clr && act_stb) begin
            x_idx   <= nxt_x_s;
            y_idx   <= nxt_y_s;
            act_cnt <= nxt_cnt_s;
            if (cnt_full_s) begin
              state_r <= FULL;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= RUN;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clr) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            x_idx   <= ZERO_W;
            y_idx   <= ZERO_W;
            act_cnt <= ZERO_W;
          end else if (act_stb) begin
            x_idx   <= nxt_x_s;
            y_idx   <= nxt_y_s;
            act_cnt <= nxt_cnt_s;
            if (cnt_full_s) begin
              state_r <= FULL;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        FULL: begin
          if (clr) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            x_idx     <= ZERO_W;
            y_idx     <= ZERO_W;
            act_cnt   <= ZERO_W;
            frame_cnt <= frame_cnt + ONE_W;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          x_idx   <= ZERO_W;
          y_idx   <= ZERO_W;
          act_cnt <= ZERO_W;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_monitor.sv
// tb_loop_nest_monitor: directed self-checking bench for loop_nest_monitor
// with OUTER=INNER=10, W=8 (frame of 100 actions).
module tb_loop_nest_monitor;

  logic       clk;
  logic       rst;
  logic       act_stb;
  logic       clr;
  logic       err_clr;
  logic [7:0] x_idx;
  logic [7:0] y_idx;
  logic [7:0] act_cnt;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;
  logic       overrun;
  logic       underrun;

  int test_cnt   = 0;
  int fail_cnt   = 0;
  int done_count = 0;
  int consec     = 0;
  logic prev_done = 1'b0;

  loop_nest_monitor #(.OUTER(10), .INNER(10), .W(8)) dut (
    .clk(clk), .rst(rst), .act_stb(act_stb), .clr(clr), .err_clr(err_clr),
    .x_idx(x_idx), .y_idx(y_idx), .act_cnt(act_cnt), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .overrun(overrun), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count and report mismatches.
  task automatic check(input string tag, input int got, input int exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; track done pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_count++;
    if (done === 1'b1 && prev_done === 1'b1) consec++;
    prev_done = done;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // n strobes, each followed by gap idle cycles.
  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      act_stb = 1'b1;
      cyc();
      act_stb = 1'b0;
      repeat (gap) cyc();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  int d0;

  initial begin
    rst = 1'b0; act_stb = 1'b0; clr = 1'b0; err_clr = 1'b0;

    // Reset values
    do_reset();
    check("rst_x", x_idx, 0);
    check("rst_y", y_idx, 0);
    check("rst_cnt", act_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_ovr", overrun, 0);
    check("rst_und", underrun, 0);

    // Back-to-back frame
    strobes(37, 0);
    check("s37_x", x_idx, 3);
    check("s37_y", y_idx, 7);
    check("s37_cnt", act_cnt, 37);
    check("s37_busy", busy, 1);
    strobes(63, 0);
    check("s100_done", done, 1);
    check("s100_cnt", act_cnt, 100);
    check("s100_x", x_idx, 0);
    check("s100_y", y_idx, 0);
    check("s100_busy", busy, 0);
    cyc();
    check("done_1cyc", done, 0);
    check("full_hold_cnt", act_cnt, 100);
    do_clr();
    check("clr_cnt", act_cnt, 0);
    check("clr_frame", frame_cnt, 1);
    check("clr_ovr", overrun, 0);
    check("clr_und", underrun, 0);
    check("clr_busy", busy, 0);

    // Three spaced frames
    do_reset();
    d0 = done_count;
    for (int f = 0; f < 3; f++) begin
      strobes(37, 2);
      check("sp37_x", x_idx, 3);
      check("sp37_y", y_idx, 7);
      strobes(63, 2);
      check("sp_cnt", act_cnt, 100);
      check("sp_xy", {x_idx, y_idx}, 0);
      do_clr();
    end
    check("sp_dones", done_count - d0, 3);
    check("sp_frame", frame_cnt, 3);
    check("sp_flags", {overrun, underrun}, 0);

    // Underrun: 42 strobes then clr
    do_reset();
    strobes(42, 0);
    check("u42_cnt", act_cnt, 42);
    do_clr();
    check("und_flag", underrun, 1);
    check("und_frame", frame_cnt, 0);
    check("und_cnt", act_cnt, 0);
    check("und_busy", busy, 0);
    check("und_xy", {x_idx, y_idx}, 0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("und_errclr", underrun, 0);

    // Overrun: extra strobes in FULL
    do_reset();
    strobes(100, 0);
    strobes(1, 0);
    check("ovr1_flag", overrun, 1);
    check("ovr1_cnt", act_cnt, 100);
    strobes(1, 0);
    check("ovr2_cnt", act_cnt, 100);
    check("ovr2_xy", {x_idx, y_idx}, 0);
    err_clr = 1'b1; act_stb = 1'b1; cyc(); err_clr = 1'b0; act_stb = 1'b0;
    check("ovr_err_wins", overrun, 1);
    do_clr();
    check("ovr_frame", frame_cnt, 1);
    check("ovr_sticky", overrun, 1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("ovr_errclr", overrun, 0);

    // Simultaneous act_stb+clr at 99: clr wins, underrun, no done
    do_reset();
    d0 = done_count;
    strobes(99, 0);
    act_stb = 1'b1; clr = 1'b1; cyc(); act_stb = 1'b0; clr = 1'b0;
    check("c99_und", underrun, 1);
    check("c99_cnt", act_cnt, 0);
    check("c99_nodone", done_count - d0, 0);
    check("c99_frame", frame_cnt, 0);

    // Simultaneous act_stb+clr in FULL: normal close
    do_reset();
    strobes(100, 0);
    act_stb = 1'b1; clr = 1'b1; cyc(); act_stb = 1'b0; clr = 1'b0;
    check("c100_frame", frame_cnt, 1);
    check("c100_ovr", overrun, 0);
    check("c100_cnt", act_cnt, 0);

    // Mid-frame reset at act_cnt=55 (frame_cnt=1 beforehand)
    strobes(55, 0);
    check("m55_cnt", act_cnt, 55);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mrst_cnt", act_cnt, 0);
    check("mrst_xy", {x_idx, y_idx}, 0);
    check("mrst_busy", busy, 0);
    check("mrst_frame", frame_cnt, 0);
    check("mrst_flags", {overrun, underrun}, 0);
    strobes(100, 0);
    check("post_done", done, 1);
    check("post_cnt", act_cnt, 100);
    do_clr();
    check("post_frame", frame_cnt, 1);
    check("post_flags", {overrun, underrun}, 0);

    check("done_never_consec", consec, 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/loop_nest_monitor.md
Name: loop_nest_monitor

Overview:
- Receiving end of the nested-loop action sequencer. Consumes one action strobe per inner-loop iteration.
- Reconstructs the outer index (x) and inner index (y).
- Detects frame completion after OUTER*INNER actions, and flags protocol violations: extra actions before the clear, or a clear before the frame is complete.
- Sits downstream of the loop sequencer as a checker/decoder and counts good frames.

Parameters:
- OUTER, 10, outer-loop trip count (>=1)
- INNER, 10, inner-loop trip count (>=1)
- W, 8, width of index and counter outputs; OUTER*INNER <= 2^W-1 required

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- act_stb  in  1  one-cycle action strobe, one per inner iteration
- clr  in  1  frame clear (the sequencer's reset-actions step)
- err_clr  in  1  clears the sticky error flags
- x_idx  out  W  outer index of the next expected action
- y_idx  out  W  inner index of the next expected action
- act_cnt  out  W  actions accepted in the current frame
- busy  out  1  high in state RUN
- done  out  1  one-cycle pulse on frame completion
- frame_cnt  out  W  completed-and-cleared frames, wraps mod 2^W
- overrun  out  1  sticky: act_stb received in FULL
- underrun  out  1  sticky: clr received with 0 < act_cnt < OUTER*INNER

Behaviour:
- The clock is one domain; reset is synchronous and active-high. While rst=1 at a rising edge, all state and outputs load reset values: state=IDLE, x_idx=0, y_idx=0, act_cnt=0, busy=0, done=0, frame_cnt=0, overrun=0, underrun=0.
- rst mid-frame aborts the frame with no flags set.
- All outputs are registered. Each effect appears the cycle after its input is sampled.
- TOTAL = OUTER*INNER.
- Index advance on an accepted act_stb:
  - If y_idx == INNER-1: y_idx <= 0.
  - If additionally x_idx == OUTER-1: x_idx <= 0.
  - Otherwise x_idx <= x_idx+1.
  - Otherwise y_idx <= y_idx+1.
  - act_cnt <= act_cnt+1 on every accepted strobe.
- States:
  - IDLE (act_cnt=0):
    - act_stb -> accept, go RUN. If TOTAL==1, go FULL directly and pulse done.
    - clr alone -> no effect, no flag.
  - RUN:
    - act_stb -> accept.
    - If the accepted strobe makes act_cnt reach TOTAL -> go FULL, done=1 for exactly one cycle. x_idx/y_idx have wrapped to 0/0.
    - clr -> underrun<=1, indices and act_cnt cleared, go IDLE, frame_cnt unchanged.
  - FULL (act_cnt=TOTAL):
    - act_stb -> overrun<=1. Strobe dropped; act_cnt and indices hold.
    - clr -> frame_cnt<=frame_cnt+1, indices and act_cnt cleared, go IDLE.
- Simultaneous act_stb and clr: clr has priority and the strobe is ignored. It is neither counted nor flagged.
- The state's clr rule applies: FULL gives a normal close; RUN gives underrun; IDLE gives no effect.
- err_clr clears overrun and underrun. If err_clr coincides with a new error event, the error wins and the flag stays 1.
- err_clr does not affect counting or state.
- frame_cnt wraps from 2^W-1 to 0 without a flag.
- done never asserts in consecutive cycles.
- busy = (state==RUN), registered.

Test Plan:
- Reset then 100 act_stb pulses (OUTER=INNER=10, back-to-back), then 1 cycle later clr:
  - after the 37th strobe: x_idx=3, y_idx=7, act_cnt=37, busy=1
  - after the 100th strobe: done=1 for one cycle, act_cnt=100, x_idx=0, y_idx=0, busy=0
  - after clr: act_cnt=0, frame_cnt=1, no flags
- Same sequence with strobes spaced 3 cycles apart, repeated 3 frames -> done pulses 3 times, frame_cnt=3, results identical to the back-to-back case.
- 42 strobes then clr -> underrun=1, frame_cnt=0, act_cnt=0, state IDLE. Then err_clr -> underrun=0.
- 100 strobes, then 2 extra strobes, then clr -> overrun=1, act_cnt stays 100 during the extras, frame_cnt=1 after clr. Same-cycle err_clr and a third extra strobe -> overrun remains 1.
- 99 strobes, then act_stb and clr in the same cycle -> strobe ignored, underrun=1, done never pulses. Separately, 100 strobes then act_stb+clr together -> normal close, frame_cnt+1, overrun=0.
- rst=1 for one cycle at act_cnt=55 -> all outputs at reset values the next cycle. A following full 100-strobe frame completes normally with done=1.
